// File: rtl/ysyx_24090003_wb_arbiter_if.sv
// Write-back bus between the EXU/LSU requesters and the arbiter.
// The arbiter takes the slave side; requesters and the RF/CSR sink take the master side.
interface ysyx_24090003_wb_arbiter_if #(
  parameter int CNT_W = 32
);
  logic             i_hold;
  logic             i_exu_valid;
  logic             o_exu_ready;
  logic [31:0]      i_exu_pc;
  logic [4:0]       i_exu_rd_addr;
  logic [31:0]      i_exu_rd_wdata;
  logic             i_exu_reg_wen;
  logic             i_exu_csr_we;
  logic [11:0]      i_exu_csr_addr;
  logic [1:0]       i_exu_csr_op;
  logic [31:0]      i_exu_csr_wdata;
  logic [4:0]       i_exu_rs1_addr;
  logic             i_exu_ecall;
  logic             i_exu_mret;
  logic             i_lsu_valid;
  logic             o_lsu_ready;
  logic [31:0]      i_lsu_pc;
  logic [4:0]       i_lsu_rd_addr;
  logic [31:0]      i_lsu_rd_wdata;
  logic             i_lsu_reg_wen;
  logic             o_reg_wen;
  logic [4:0]       o_rd_addr;
  logic [31:0]      o_rd_wdata;
  logic             o_csr_we;
  logic [11:0]      o_csr_addr;
  logic [1:0]       o_csr_op;
  logic [31:0]      o_csr_wdata;
  logic [4:0]       o_rs1_addr;
  logic             o_ecall;
  logic             o_mret;
  logic [31:0]      o_pc;
  logic             o_retire;
  logic [CNT_W-1:0] o_retire_cnt;

  modport slave (
    input  i_hold,
    input  i_exu_valid, i_exu_pc, i_exu_rd_addr,
    input  i_exu_rd_wdata, i_exu_reg_wen,
    input  i_exu_csr_we, i_exu_csr_addr,
    input  i_exu_csr_op, i_exu_csr_wdata,
    input  i_exu_rs1_addr, i_exu_ecall, i_exu_mret,
    input  i_lsu_valid, i_lsu_pc, i_lsu_rd_addr,
    input  i_lsu_rd_wdata, i_lsu_reg_wen,
    output o_exu_ready, o_lsu_ready,
    output o_reg_wen, o_rd_addr, o_rd_wdata,
    output o_csr_we, o_csr_addr, o_csr_op,
    output o_csr_wdata, o_rs1_addr,
    output o_ecall, o_mret, o_pc,
    output o_retire, o_retire_cnt
  );

  modport master (
    output i_hold,
    output i_exu_valid, i_exu_pc, i_exu_rd_addr,
    output i_exu_rd_wdata, i_exu_reg_wen,
    output i_exu_csr_we, i_exu_csr_addr,
    output i_exu_csr_op, i_exu_csr_wdata,
    output i_exu_rs1_addr, i_exu_ecall, i_exu_mret,
    output i_lsu_valid, i_lsu_pc, i_lsu_rd_addr,
    output i_lsu_rd_wdata, i_lsu_reg_wen,
    input  o_exu_ready, o_lsu_ready,
    input  o_reg_wen, o_rd_addr, o_rd_wdata,
    input  o_csr_we, o_csr_addr, o_csr_op,
    input  o_csr_wdata, o_rs1_addr,
    input  o_ecall, o_mret, o_pc,
    input  o_retire, o_retire_cnt
  );
endinterface

// File: rtl/ysyx_24090003_wb_arbiter.sv
// Round-robin write-back arbiter for EXU/LSU onto the single RF/CSR write port.
// Registers the winner into a one-cycle write pulse and counts retirements.
module ysyx_24090003_wb_arbiter #(
  parameter logic PRIO_RESET = 1'b0,
  parameter int   CNT_W      = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  ysyx_24090003_wb_arbiter_if.slave bus
);
  logic ptr;
  logic both;
  logic exu_fire;
  logic lsu_fire;

  assign both = bus.i_exu_valid & bus.i_lsu_valid;

  // ptr = 1 means LSU is favoured when both request
  assign bus.o_exu_ready = i_rst_n & ~bus.i_hold
                         & bus.i_exu_valid
                         & (~bus.i_lsu_valid | ~ptr);
  assign bus.o_lsu_ready = i_rst_n & ~bus.i_hold
                         & bus.i_lsu_valid
                         & (~bus.i_exu_valid | ptr);

  assign exu_fire = bus.i_exu_valid & bus.o_exu_ready;
  assign lsu_fire = bus.i_lsu_valid & bus.o_lsu_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr              <= PRIO_RESET;
      bus.o_reg_wen    <= 1'b0;
      bus.o_rd_addr    <= '0;
      bus.o_rd_wdata   <= '0;
      bus.o_csr_we     <= 1'b0;
      bus.o_csr_addr   <= '0;
      bus.o_csr_op     <= '0;
      bus.o_csr_wdata  <= '0;
      bus.o_rs1_addr   <= '0;
      bus.o_ecall      <= 1'b0;
      bus.o_mret       <= 1'b0;
      bus.o_pc         <= '0;
      bus.o_retire     <= 1'b0;
      bus.o_retire_cnt <= '0;
    end else begin
      bus.o_retire  <= exu_fire | lsu_fire;
      bus.o_reg_wen <= 1'b0;
      bus.o_csr_we  <= 1'b0;
      bus.o_ecall   <= 1'b0;
      bus.o_mret    <= 1'b0;
      unique case (1'b1)
        exu_fire: begin
          bus.o_pc        <= bus.i_exu_pc;
          bus.o_rd_addr   <= bus.i_exu_rd_addr;
          bus.o_rd_wdata  <= bus.i_exu_rd_wdata;
          bus.o_reg_wen   <= bus.i_exu_reg_wen
                           & (|bus.i_exu_rd_addr);
          bus.o_csr_addr  <= bus.i_exu_csr_addr;
          bus.o_csr_op    <= bus.i_exu_csr_op;
          bus.o_csr_wdata <= bus.i_exu_csr_wdata;
          bus.o_rs1_addr  <= bus.i_exu_rs1_addr;
          // traps pre-empt the CSR write; ecall beats mret
          bus.o_ecall     <= bus.i_exu_ecall;
          bus.o_mret      <= bus.i_exu_mret
                           & ~bus.i_exu_ecall;
          bus.o_csr_we    <= bus.i_exu_csr_we
                           & ~bus.i_exu_ecall
                           & ~bus.i_exu_mret;
        end
        lsu_fire: begin
          bus.o_pc        <= bus.i_lsu_pc;
          bus.o_rd_addr   <= bus.i_lsu_rd_addr;
          bus.o_rd_wdata  <= bus.i_lsu_rd_wdata;
          bus.o_reg_wen   <= bus.i_lsu_reg_wen
                           & (|bus.i_lsu_rd_addr);
          bus.o_csr_addr  <= '0;
          bus.o_csr_op    <= '0;
          bus.o_csr_wdata <= '0;
          bus.o_rs1_addr  <= '0;
        end
        default: ;
      endcase
      if (both & (exu_fire | lsu_fire))
        ptr <= exu_fire;
      if (exu_fire | lsu_fire)
        bus.o_retire_cnt <= bus.o_retire_cnt + 1'b1;
    end
  end
endmodule
